rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order retirement engine at the head (read end) of the reorder buffer.
- Examines the head entry (State[9:8], S[7], ST[6], V[5], Preg[4:0]) and pops it once Finished and non-speculative.
- Returns valid destination PRF registers to the free list and performs a req/ack handshake with the store buffer for store entries.
- On squash, drains speculative entries from the head, freeing their Pregs without counting commits.

Parameters:
- PREG_W, 5, PRF address width (Preg field [PREG_W-1:0]).
- CNT_W, 16, width of commit counter.
- STALL_LIMIT, 255, head-blocked cycles before stall flag asserts (must fit in 8 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- head_valid  in  1  ROB not empty; head_entry is meaningful.
- head_entry  in  10  ROB head line: [9:8] State (00 Free, 01 Pending, 10 Finished, 11 reserved), [7] S, [6] ST, [5] V, [4:0] Preg.
- squash  in  1  single-cycle pulse: discard speculative entries.
- head_pop  out  1  one-cycle pulse: ROB advances head.
- st_req  out  1  store commit request, level, held until ack.
- st_preg  out  PREG_W  Preg of the store being committed.
- st_ack  in  1  store buffer accepted the request.
- free_valid  out  1  one-cycle pulse: free_preg returned to free list.
- free_preg  out  PREG_W  freed PRF address.
- commit_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- stall  out  1  head blocked for STALL_LIMIT consecutive cycles.

Behaviour:
- Reset (rst=0 at posedge): FSM=IDLE; all outputs, squash_pend and stall_cnt = 0. Reset overrides everything, including an in-flight st_req (dropped the next cycle).
- All outputs registered; decisions use inputs sampled at posedge.
- States: IDLE, ST_WAIT, GAP, SQ_POP, SQ_GAP.
- IDLE:
  - squash=1 -> SQ_POP (squash has priority over retire).
  - Else if head_valid, State=10 and S=0:
    - ST=1 -> ST_WAIT; next cycle st_req=1, st_preg=Preg.
    - ST=0 -> GAP; next cycle head_pop=1, free_valid=V, free_preg=Preg, commit_count+1.
  - Else stay in IDLE. State 00 or 11 at the head is treated as not retirable.
- ST_WAIT:
  - st_req held at 1 with st_preg stable until st_ack=1 is sampled.
  - On ack -> GAP; next cycle st_req=0, head_pop=1, free_valid=V, commit_count+1.
  - squash during ST_WAIT sets squash_pend and does not abort the store (the entry is non-speculative).
  - st_ack outside ST_WAIT is ignored.
- GAP: one bubble cycle so the ROB head can update.
  - -> SQ_POP if squash or squash_pend (clear squash_pend).
  - Else -> IDLE.
  - Peak throughput: 1 commit per 2 cycles.
- SQ_POP:
  - If head_valid and S=1: next cycle head_pop=1, free_valid=V, free_preg=Preg, no commit increment; -> SQ_GAP.
  - Else -> IDLE (drain done).
- SQ_GAP: -> SQ_POP. A squash arriving in SQ_POP/SQ_GAP is absorbed (the drain is already running).
- stall_cnt (8 bits):
  - Increments, saturating at STALL_LIMIT, in IDLE when head_valid and the head is not retirable.
  - Clears on any head_pop or when head_valid=0.
  - stall = (stall_cnt == STALL_LIMIT).
- head_pop is never asserted on two consecutive cycles, and never when head_valid was 0 at the deciding edge.

Optional Feature:
- Macro COMMIT_PERF_EN.
- Defined:
  - Adds output ports perf_store_cnt (CNT_W) and perf_squash_cnt (CNT_W).
  - perf_store_cnt increments on each store retire (the ack-driven pop).
  - perf_squash_cnt increments on each squash-drain pop.
  - Both reset to 0 and wrap.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then head_valid=1, head_entry=10'b10_0_0_1_00111 -> at cycle 2: head_pop=1, free_valid=1, free_preg=7, commit_count=1; head_pop=0 the following cycle.
- Head State=01 held 300 cycles with STALL_LIMIT=255 -> no pop; stall=1 from cycle 256; flip State to 10 -> pop, then stall=0.
- Store head 10'b10_0_1_0_00011, st_ack low for 5 cycles -> st_req=1, st_preg=3 throughout; ack -> next cycle head_pop=1, free_valid=0, st_req=0, commit_count+1.
- Squash pulse with three heads S=1 (Preg 4, 5, 6; V=1) followed by S=0 -> pops on alternate cycles with free_preg 4, 5, 6; commit_count unchanged; returns to IDLE.
- Squash during ST_WAIT -> store completes on ack and is counted, then the drain runs after GAP.
- rst=0 asserted while st_req=1 -> next cycle st_req, head_pop, free_valid and commit_count all 0; FSM in IDLE.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement at the ROB head. It frees destination Pregs, handshakes stores with the
// store buffer and drains speculative entries on squash. Define COMMIT_PERF_EN to add the perf counter ports.
module rob_commit #(
   parameter int PREG_W      = 5,
   parameter int CNT_W       = 16,
   parameter int STALL_LIMIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              head_valid,
   input  logic [9:0]        head_entry,
   input  logic              squash,
   output logic              head_pop,
   output logic              st_req,
   output logic [PREG_W-1:0] st_preg,
   input  logic              st_ack,
   output logic              free_valid,
   output logic [PREG_W-1:0] free_preg,
   output logic [CNT_W-1:0]  commit_count,
   output logic              stall
`ifdef COMMIT_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_store_cnt,
   output logic [CNT_W-1:0]  perf_squash_cnt
`endif
);

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ST_WAIT = 3'd1,
      GAP     = 3'd2,
      SQ_POP  = 3'd3,
      SQ_GAP  = 3'd4
   } state_t;

   state_t state, state_n;

   // head entry fields
   logic [1:0]        h_state;
   logic              h_s, h_st, h_v;
   logic [PREG_W-1:0] h_preg;
   logic              retirable;

   assign h_state   = head_entry[9:8];
   assign h_s       = head_entry[7];
   assign h_st      = head_entry[6];
   assign h_v       = head_entry[5];
   assign h_preg    = head_entry[PREG_W-1:0];
   assign retirable = head_valid && (h_state == 2'b10) && !h_s;

   logic              st_v, st_v_n;
   logic              squash_pend, pend_n;
   logic [7:0]        stall_cnt, cnt_n;
   logic              pop_n, free_v_n, commit_n, st_req_n;
   logic [PREG_W-1:0] free_p_n, st_preg_n;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n   = state;
      pop_n     = 1'b0;
      free_v_n  = 1'b0;
      free_p_n  = free_preg;
      commit_n  = 1'b0;
      st_req_n  = st_req;
      st_preg_n = st_preg;
      st_v_n    = st_v;
      pend_n    = squash_pend;
      case (state)
         IDLE: begin
            if (squash) begin
               state_n = SQ_POP;
            end else if (retirable) begin
               if (h_st) begin
                  state_n   = ST_WAIT;
                  st_req_n  = 1'b1;
                  st_preg_n = h_preg;
                  st_v_n    = h_v;
               end else begin
                  state_n  = GAP;
                  pop_n    = 1'b1;
                  free_v_n = h_v;
                  free_p_n = h_preg;
                  commit_n = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            // The store is already non-speculative, so a squash only queues the drain behind it.
            if (squash) pend_n = 1'b1;
            if (st_ack) begin
               state_n  = GAP;
               st_req_n = 1'b0;
               pop_n    = 1'b1;
               free_v_n = st_v;
               free_p_n = st_preg;
               commit_n = 1'b1;
            end
         end
         GAP: begin
            if (squash || squash_pend) begin
               state_n = SQ_POP;
               pend_n  = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         SQ_POP: begin
            if (head_valid && h_s) begin
               state_n  = SQ_GAP;
               pop_n    = 1'b1;
               free_v_n = h_v;
               free_p_n = h_preg;
            end else begin
               state_n = IDLE;
            end
         end
         SQ_GAP:  state_n = SQ_POP;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cnt_n = stall_cnt;
      if (!head_valid || pop_n)
         cnt_n = '0;
      else if (state == IDLE && !retirable && stall_cnt != LIMIT)
         cnt_n = stall_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_pop     <= 1'b0;
         free_valid   <= 1'b0;
         free_preg    <= '0;
         st_req       <= 1'b0;
         st_preg      <= '0;
         st_v         <= 1'b0;
         squash_pend  <= 1'b0;
         commit_count <= '0;
         stall_cnt    <= '0;
         stall        <= 1'b0;
      end else begin
         head_pop    <= pop_n;
         free_valid  <= free_v_n;
         free_preg   <= free_p_n;
         st_req      <= st_req_n;
         st_preg     <= st_preg_n;
         st_v        <= st_v_n;
         squash_pend <= pend_n;
         if (commit_n) commit_count <= commit_count + CNT_W'(1);
         stall_cnt   <= cnt_n;
         stall       <= (cnt_n == LIMIT);
      end
   end

`ifdef COMMIT_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_store_cnt  <= '0;
         perf_squash_cnt <= '0;
      end else begin
         if (state == ST_WAIT && st_ack) perf_store_cnt  <= perf_store_cnt + CNT_W'(1);
         if (state == SQ_POP && pop_n)   perf_squash_cnt <= perf_squash_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus randomized ROB/store-buffer traffic
// scored against a queue model of the reorder buffer.
module tb_rob_commit;
   localparam int PREG_W = 5;
   localparam int CNT_W  = 16;
   localparam int STALL_LIMIT = 255;

   logic clk, rst, head_valid, squash, st_ack;
   logic [9:0] head_entry;
   logic head_pop, st_req, free_valid, stall;
   logic [PREG_W-1:0] st_preg, free_preg;
   logic [CNT_W-1:0]  commit_count;
`ifdef COMMIT_PERF_EN
   logic [CNT_W-1:0]  perf_store_cnt, perf_squash_cnt;
`endif

   int checks, failures;
   int exp_commit, exp_store, exp_sq;
   logic [9:0] rob_q[$];

   rob_commit #(.PREG_W(PREG_W), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)) dut (
      .clk(clk), .rst(rst), .head_valid(head_valid), .head_entry(head_entry), .squash(squash),
      .head_pop(head_pop), .st_req(st_req), .st_preg(st_preg), .st_ack(st_ack),
      .free_valid(free_valid), .free_preg(free_preg), .commit_count(commit_count), .stall(stall)
`ifdef COMMIT_PERF_EN
      , .perf_store_cnt(perf_store_cnt), .perf_squash_cnt(perf_squash_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   function automatic logic [9:0] ent(input logic [1:0] st, input logic s, input logic stb,
                                      input logic v, input logic [4:0] p);
      return {st, s, stb, v, p};
   endfunction

   task automatic drive_head;
      head_valid = (rob_q.size() != 0);
      head_entry = (rob_q.size() != 0) ? rob_q[0] : 10'd0;
   endtask

   task automatic test_reset;
      rst = 1'b0; head_valid = 1'b1; head_entry = ent(2'b10, 0, 0, 1, 5'd7); squash = 1'b1; st_ack = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (head_pop !== 1'b0) begin failures++; $display("FAIL reset_head_pop: got %b want 0", head_pop); end
      checks++; if (free_valid !== 1'b0) begin failures++; $display("FAIL reset_free_valid: got %b want 0", free_valid); end
      checks++; if (st_req !== 1'b0) begin failures++; $display("FAIL reset_st_req: got %b want 0", st_req); end
      checks++; if (commit_count !== 16'd0) begin failures++; $display("FAIL reset_commit: got %0d want 0", commit_count); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (free_preg !== 5'd0 || st_preg !== 5'd0) begin failures++; $display("FAIL reset_pregs: got %0d/%0d want 0/0", free_preg, st_preg); end
      rst = 1'b1; head_valid = 1'b0; squash = 1'b0; st_ack = 1'b0;
      exp_commit = 0; exp_store = 0; exp_sq = 0;
   endtask

   task automatic test_basic_retire;
      head_valid = 1'b1; head_entry = ent(2'b10, 0, 0, 1, 5'd7);
      @(negedge clk);
      exp_commit++;
      checks++; if (head_pop !== 1'b1) begin failures++; $display("FAIL basic_pop: got %b want 1", head_pop); end
      checks++; if (free_valid !== 1'b1 || free_preg !== 5'd7) begin failures++; $display("FAIL basic_free: got %b/%0d want 1/7", free_valid, free_preg); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL basic_commit: got %0d want %0d", commit_count, exp_commit); end
      head_valid = 1'b0;
      @(negedge clk);
      checks++; if (head_pop !== 1'b0 || free_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse: got %b/%b want 0/0", head_pop, free_valid); end
   endtask

   task automatic test_stall;
      logic popped;
      popped = 1'b0;
      head_valid = 1'b1; head_entry = ent(2'b01, 0, 0, 1, 5'd20);
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (head_pop === 1'b1) popped = 1'b1;
         if (i == 254) begin
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_early: got %b want 0", stall); end
         end
         if (i == 255 || i == 300) begin
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_set_%0d: got %b want 1", i, stall); end
         end
      end
      checks++; if (popped !== 1'b0) begin failures++; $display("FAIL stall_no_pop: got %b want 0", popped); end
      head_entry = ent(2'b10, 0, 0, 1, 5'd20);
      @(negedge clk);
      exp_commit++;
      checks++; if (head_pop !== 1'b1 || free_preg !== 5'd20) begin failures++; $display("FAIL stall_release_pop: got %b/%0d want 1/20", head_pop, free_preg); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_clear: got %b want 0", stall); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL stall_commit: got %0d want %0d", commit_count, exp_commit); end
      head_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store;
      head_valid = 1'b1; head_entry = ent(2'b10, 0, 1, 0, 5'd3); st_ack = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++; if (st_req !== 1'b1 || st_preg !== 5'd3 || head_pop !== 1'b0) begin
            failures++; $display("FAIL store_wait_%0d: got req=%b preg=%0d pop=%b want 1/3/0", i, st_req, st_preg, head_pop); end
         if (i < 5) @(negedge clk);
      end
      st_ack = 1'b1;
      @(negedge clk);
      exp_commit++; exp_store++;
      st_ack = 1'b0;
      checks++; if (head_pop !== 1'b1 || free_valid !== 1'b0 || st_req !== 1'b0) begin
         failures++; $display("FAIL store_done: got pop=%b fv=%b req=%b want 1/0/0", head_pop, free_valid, st_req); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL store_commit: got %0d want %0d", commit_count, exp_commit); end
      head_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_squash_drain;
      int pops, last;
      logic [4:0] want[3];
      want = '{5'd4, 5'd5, 5'd6};
      rob_q = '{ent(2'b01, 1, 0, 1, 5'd4), ent(2'b10, 1, 0, 1, 5'd5), ent(2'b01, 1, 1, 1, 5'd6), ent(2'b01, 0, 0, 0, 5'd13)};
      drive_head();
      squash = 1'b1; pops = 0; last = -10;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         squash = 1'b0;
         if (head_pop === 1'b1) begin
            if (pops < 3) begin
               checks++; if (free_valid !== 1'b1 || free_preg !== want[pops]) begin
                  failures++; $display("FAIL drain_free_%0d: got %b/%0d want 1/%0d", pops, free_valid, free_preg, want[pops]); end
            end
            if (pops > 0) begin
               checks++; if (c - last != 2) begin failures++; $display("FAIL drain_spacing: got %0d want 2", c - last); end
            end
            last = c; pops++; exp_sq++;
            if (rob_q.size() != 0) void'(rob_q.pop_front());
            drive_head();
         end
      end
      checks++; if (pops != 3) begin failures++; $display("FAIL drain_count: got %0d want 3", pops); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL drain_commit: got %0d want %0d", commit_count, exp_commit); end
      rob_q.delete(); rob_q.push_back(ent(2'b10, 0, 0, 0, 5'd13));
      drive_head();
      @(negedge clk);
      exp_commit++;
      checks++; if (head_pop !== 1'b1 || commit_count !== 16'(exp_commit)) begin
         failures++; $display("FAIL drain_idle: got pop=%b cnt=%0d want 1/%0d", head_pop, commit_count, exp_commit); end
      rob_q.delete(); drive_head();
      @(negedge clk);
   endtask

   task automatic test_squash_in_store;
      int pops;
      logic [4:0] want_p[2];
      logic       want_v[2];
      want_p = '{5'd10, 5'd11}; want_v = '{1'b1, 1'b0};
      rob_q = '{ent(2'b10, 0, 1, 1, 5'd9), ent(2'b01, 1, 0, 1, 5'd10), ent(2'b10, 1, 0, 0, 5'd11), ent(2'b01, 0, 0, 0, 5'd12)};
      drive_head();
      @(negedge clk);
      checks++; if (st_req !== 1'b1) begin failures++; $display("FAIL sqst_req: got %b want 1", st_req); end
      squash = 1'b1;
      @(negedge clk);
      squash = 1'b0;
      checks++; if (st_req !== 1'b1 || head_pop !== 1'b0) begin failures++; $display("FAIL sqst_hold: got req=%b pop=%b want 1/0", st_req, head_pop); end
      st_ack = 1'b1;
      @(negedge clk);
      st_ack = 1'b0; exp_commit++; exp_store++;
      checks++; if (head_pop !== 1'b1 || free_valid !== 1'b1 || free_preg !== 5'd9 || st_req !== 1'b0) begin
         failures++; $display("FAIL sqst_store_pop: got pop=%b fv=%b fp=%0d req=%b want 1/1/9/0", head_pop, free_valid, free_preg, st_req); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL sqst_commit: got %0d want %0d", commit_count, exp_commit); end
      void'(rob_q.pop_front()); drive_head();
      pops = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (head_pop === 1'b1) begin
            if (pops < 2) begin
               checks++; if (free_valid !== want_v[pops] || (want_v[pops] && free_preg !== want_p[pops])) begin
                  failures++; $display("FAIL sqst_drain_%0d: got %b/%0d want %b/%0d", pops, free_valid, free_preg, want_v[pops], want_p[pops]); end
            end
            pops++; exp_sq++;
            if (rob_q.size() != 0) void'(rob_q.pop_front());
            drive_head();
         end
      end
      checks++; if (pops != 2) begin failures++; $display("FAIL sqst_drain_count: got %0d want 2", pops); end
      checks++; if (commit_count !== 16'(exp_commit)) begin failures++; $display("FAIL sqst_drain_commit: got %0d want %0d", commit_count, exp_commit); end
      rob_q.delete(); drive_head();
      @(negedge clk);
   endtask

   task automatic test_random;
      int k, n, cyc, delay;
      logic [9:0] e;
      logic prev_pop, saw_req, sq_round;
      for (int r = 0; r < 40; r++) begin
         rob_q.delete();
         sq_round = ($urandom_range(0, 2) == 0);
         if (sq_round) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++)
               rob_q.push_back(ent(2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))));
         end
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++)
            rob_q.push_back(ent(2'b10, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))));
         drive_head();
         squash = sq_round;
         prev_pop = 1'b0; saw_req = 1'b0; delay = $urandom_range(0, 4); cyc = 0;
         while (rob_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            squash = 1'b0;
            if (head_pop === 1'b1) begin
               checks++; if (prev_pop) begin failures++; $display("FAIL rnd_back_to_back: got 1 want 0 (round %0d)", r); end
               e = rob_q.pop_front();
               checks++; if (free_valid !== e[5] || (e[5] && free_preg !== e[4:0])) begin
                  failures++; $display("FAIL rnd_free: got %b/%0d want %b/%0d (round %0d)", free_valid, free_preg, e[5], e[4:0], r); end
               if (!e[7]) begin
                  exp_commit++;
                  if (e[6]) begin
                     exp_store++;
                     checks++; if (!saw_req) begin failures++; $display("FAIL rnd_store_no_req: got 0 want 1 (round %0d)", r); end
                  end
               end else begin
                  exp_sq++;
               end
               checks++; if (commit_count !== 16'(exp_commit)) begin
                  failures++; $display("FAIL rnd_commit: got %0d want %0d (round %0d)", commit_count, exp_commit, r); end
               saw_req = 1'b0;
            end
            prev_pop = (head_pop === 1'b1);
            if (st_req === 1'b1) begin
               saw_req = 1'b1;
               checks++; if (rob_q.size() == 0 || st_preg !== rob_q[0][4:0]) begin
                  failures++; $display("FAIL rnd_st_preg: got %0d want head preg (round %0d)", st_preg, r); end
            end
            if (st_req === 1'b1 && st_ack == 1'b0) begin
               if (delay == 0) begin st_ack = 1'b1; delay = $urandom_range(0, 4); end
               else delay--;
            end else begin
               st_ack = 1'b0;
            end
            drive_head();
         end
         checks++; if (rob_q.size() != 0) begin failures++; $display("FAIL rnd_timeout: got %0d left want 0 (round %0d)", rob_q.size(), r); end
         rob_q.delete(); drive_head(); st_ack = 1'b0; squash = 1'b0;
         @(negedge clk);
         checks++; if (head_pop !== 1'b0) begin failures++; $display("FAIL rnd_idle_pop: got %b want 0 (round %0d)", head_pop, r); end
      end
   endtask

`ifdef COMMIT_PERF_EN
   task automatic test_perf;
      checks++; if (perf_store_cnt !== 16'(exp_store)) begin failures++; $display("FAIL perf_store: got %0d want %0d", perf_store_cnt, exp_store); end
      checks++; if (perf_squash_cnt !== 16'(exp_sq)) begin failures++; $display("FAIL perf_squash: got %0d want %0d", perf_squash_cnt, exp_sq); end
   endtask
`endif

   task automatic test_reset_mid_store;
      head_valid = 1'b1; head_entry = ent(2'b10, 0, 1, 1, 5'd8); st_ack = 1'b0;
      @(negedge clk);
      checks++; if (st_req !== 1'b1) begin failures++; $display("FAIL rstmid_req: got %b want 1", st_req); end
      rst = 1'b0;
      @(negedge clk);
      exp_commit = 0;
      checks++; if (st_req !== 1'b0 || head_pop !== 1'b0 || free_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_outs: got req=%b pop=%b fv=%b want 0/0/0", st_req, head_pop, free_valid); end
      checks++; if (commit_count !== 16'd0) begin failures++; $display("FAIL rstmid_commit: got %0d want 0", commit_count); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (st_req !== 1'b1 || st_preg !== 5'd8) begin failures++; $display("FAIL rstmid_idle: got %b/%0d want 1/8", st_req, st_preg); end
      st_ack = 1'b1;
      @(negedge clk);
      st_ack = 1'b0; exp_commit++;
      checks++; if (head_pop !== 1'b1 || commit_count !== 16'(exp_commit)) begin
         failures++; $display("FAIL rstmid_retire: got pop=%b cnt=%0d want 1/%0d", head_pop, commit_count, exp_commit); end
      head_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0;
      head_entry = 10'd0;
      test_reset();
      test_basic_retire();
      test_stall();
      test_store();
      test_squash_drain();
      test_squash_in_store();
      test_random();
`ifdef COMMIT_PERF_EN
      test_perf();
`endif
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
